// File: rtl/tile_fetch_ctrl.sv
// tile_fetch_ctrl: read-side initiator for the tiled single-port matrix memory.
// Walks a row-major matrix tile by tile. For each tile it issues the tile address
// and the column stride, captures the combinational read window into a register
// buffer, and offers that buffer downstream over a valid/ready handshake.
// Optional feature macro: TILE_FETCH_ZERO_PAD_EN. When it is defined, ragged edge
// tiles are accepted and their out-of-matrix elements are captured as zero.
module tile_fetch_ctrl #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned DataDepth = 1024,
  parameter int unsigned AddrWidth = (DataDepth > 1) ? $clog2(DataDepth) : 1,
  parameter int unsigned TileRows  = 4,
  parameter int unsigned TileCols  = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         start_i,
  input  logic [AddrWidth-1:0]                         base_addr_i,
  input  logic [6:0]                                   mat_rows_i,
  input  logic [6:0]                                   mat_cols_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         err_o,
  output logic [AddrWidth-1:0]                         mem_addr_o,
  output logic [6:0]                                   mem_col_o,
  input  logic [TileRows*TileCols-1:0][DataWidth-1:0]  mem_rd_data_i,
  output logic                                         tile_valid_o,
  input  logic                                         tile_ready_i,
  output logic [TileRows*TileCols-1:0][DataWidth-1:0]  tile_data_o,
  output logic [6:0]                                   tile_row_o,
  output logic [6:0]                                   tile_col_o,
  output logic                                         tile_last_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                state_q;
  logic [AddrWidth-1:0]  base_q;
  logic [6:0]            cols_q;
  logic [6:0]            tr_q, tc_q;
  logic [6:0]            ntr_q, ntc_q;
  logic [6:0]            tr_nxt, tc_nxt;
  logic [6:0]            ntr_start, ntc_start;
  logic                  dims_bad;
  logic                  is_last;
  logic [TileRows*TileCols-1:0][DataWidth-1:0] tile_next;
`ifdef TILE_FETCH_ZERO_PAD_EN
  logic [6:0]            rows_q;
`endif

  // Top-left address of tile (tr, tc), computed wide and wrapped to the memory.
  function automatic logic [AddrWidth-1:0] tile_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [6:0] cols,
                                                     input logic [6:0] tr,
                                                     input logic [6:0] tc);
    logic [63:0] full;
    full = 64'(base) + 64'(tr) * 64'(TileRows) * 64'(cols) + 64'(tc) * 64'(TileCols);
    return full[AddrWidth-1:0];
  endfunction

  // Dimension legality and tile-grid size for a start request.
  always_comb begin
    dims_bad  = (mat_rows_i == '0) || (mat_cols_i == '0);
`ifndef TILE_FETCH_ZERO_PAD_EN
    if (((32'(mat_rows_i) % TileRows) != 0) || ((32'(mat_cols_i) % TileCols) != 0))
      dims_bad = 1'b1;
`endif
    ntr_start = 7'((32'(mat_rows_i) + TileRows - 1) / TileRows);
    ntc_start = 7'((32'(mat_cols_i) + TileCols - 1) / TileCols);
  end

  // Row-major tile walk: next tile indices and last-tile detection.
  always_comb begin
    is_last = (tr_q == ntr_q - 7'd1) && (tc_q == ntc_q - 7'd1);
    if (tc_q == ntc_q - 7'd1) begin
      tc_nxt = '0;
      tr_nxt = tr_q + 7'd1;
    end else begin
      tc_nxt = tc_q + 7'd1;
      tr_nxt = tr_q;
    end
  end

  // Tile buffer input: the read window, with out-of-matrix elements zeroed when padding.
  always_comb begin
    tile_next = mem_rd_data_i;
`ifdef TILE_FETCH_ZERO_PAD_EN
    for (int unsigned r = 0; r < TileRows; r++) begin
      for (int unsigned c = 0; c < TileCols; c++) begin
        if (((32'(tr_q) * TileRows + r) >= 32'(rows_q)) ||
            ((32'(tc_q) * TileCols + c) >= 32'(cols_q)))
          tile_next[r*TileCols+c] = '0;
      end
    end
`endif
  end

  // Control FSM with registered outputs. The address of the next tile is loaded
  // on entry to FETCH so the memory window is valid during the FETCH cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cols_q       <= '0;
      tr_q         <= '0;
      tc_q         <= '0;
      ntr_q        <= '0;
      ntc_q        <= '0;
`ifdef TILE_FETCH_ZERO_PAD_EN
      rows_q       <= '0;
`endif
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      mem_addr_o   <= '0;
      mem_col_o    <= '0;
      tile_valid_o <= 1'b0;
      tile_data_o  <= '0;
      tile_row_o   <= '0;
      tile_col_o   <= '0;
      tile_last_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q    <= base_addr_i;
            cols_q    <= mat_cols_i;
`ifdef TILE_FETCH_ZERO_PAD_EN
            rows_q    <= mat_rows_i;
`endif
            mem_col_o <= mat_cols_i;
            ntr_q     <= ntr_start;
            ntc_q     <= ntc_start;
            tr_q      <= '0;
            tc_q      <= '0;
            err_o     <= dims_bad;
            busy_o    <= 1'b1;
            if (dims_bad) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              mem_addr_o <= tile_addr(base_addr_i, mat_cols_i, '0, '0);
              state_q    <= FETCH;
            end
          end
        end
        FETCH: begin
          tile_data_o  <= tile_next;
          tile_row_o   <= tr_q;
          tile_col_o   <= tc_q;
          tile_last_o  <= is_last;
          tile_valid_o <= 1'b1;
          state_q      <= SEND;
        end
        SEND: begin
          if (tile_ready_i) begin
            tile_valid_o <= 1'b0;
            if (tile_last_o) begin
              done_o  <= 1'b1;
              state_q <= DONE;
            end else begin
              tr_q       <= tr_nxt;
              tc_q       <= tc_nxt;
              mem_addr_o <= tile_addr(base_q, cols_q, tr_nxt, tc_nxt);
              state_q    <= FETCH;
            end
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Self-checking bench for tile_fetch_ctrl: random memory contents, a matrix-level
// reference model, and scenario tasks run in sequence.
module tb_tile_fetch_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned TR    = 4;
  localparam int unsigned TC    = 4;
  localparam int unsigned NE    = TR * TC;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   start_i = 1'b0;
  logic [AW-1:0]          base_addr_i = '0;
  logic [6:0]             mat_rows_i = '0;
  logic [6:0]             mat_cols_i = '0;
  logic                   busy_o, done_o, err_o;
  logic [AW-1:0]          mem_addr_o;
  logic [6:0]             mem_col_o;
  logic [NE-1:0][DW-1:0]  mem_rd_data_i;
  logic                   tile_valid_o;
  logic                   tile_ready_i = 1'b0;
  logic [NE-1:0][DW-1:0]  tile_data_o;
  logic [6:0]             tile_row_o, tile_col_o;
  logic                   tile_last_o;

  logic [DW-1:0] mem [DEPTH];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tile_fetch_ctrl #(
    .DataWidth(DW), .DataDepth(DEPTH), .AddrWidth(AW), .TileRows(TR), .TileCols(TC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .mat_rows_i(mat_rows_i), .mat_cols_i(mat_cols_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .mem_addr_o(mem_addr_o), .mem_col_o(mem_col_o),
    .mem_rd_data_i(mem_rd_data_i), .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .tile_data_o(tile_data_o), .tile_row_o(tile_row_o), .tile_col_o(tile_col_o),
    .tile_last_o(tile_last_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory device: combinational window at mem_addr_o with row stride mem_col_o.
  always_comb begin
    mem_rd_data_i = '0;
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++)
        mem_rd_data_i[r*TC+c] = mem[(int'(mem_addr_o) + r * int'(mem_col_o) + c) % DEPTH];
  end

  // Reference: tile (tr,tc) holds matrix elements (tr*TR+r, tc*TC+c); outside the matrix, 0.
  function automatic logic [NE-1:0][DW-1:0] exp_tile(input int base, input int rows,
                                                      input int cols, input int tr, input int tc);
    logic [NE-1:0][DW-1:0] t;
    int row, col;
    for (int e = 0; e < NE; e++) begin
      row = tr * TR + e / TC;
      col = tc * TC + e % TC;
      if (row < rows && col < cols) t[e] = mem[(base + row * cols + col) % DEPTH];
      else t[e] = '0;
    end
    return t;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, done_o, err_o, tile_valid_o, tile_last_o} !== 5'b0 || mem_addr_o !== '0 ||
        mem_col_o !== '0 || tile_data_o !== '0 || tile_row_o !== '0 || tile_col_o !== '0)
      begin failures++; $display("FAIL reset_outputs: busy=%b done=%b err=%b valid=%b addr=%0d col=%0d, expected all 0",
                                 busy_o, done_o, err_o, tile_valid_o, mem_addr_o, mem_col_o); end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tile_valid_o !== 1'b0 || done_o !== 1'b0)
      begin failures++; $display("FAIL reset_idle: busy=%b valid=%b done=%b, expected 0 0 0", busy_o, tile_valid_o, done_o); end
  endtask

  // Full transfer of one matrix with randomized ready, checking every presented tile.
  task automatic run_matrix(input int base, input int rows, input int cols,
                            input int ready_pct, input bit chk_timing);
    int ntr, ntc, n, idx, budget, c0, etr, ec, ea;
    logic [NE-1:0][DW-1:0] et;
    ntr = (rows + TR - 1) / TR;
    ntc = (cols + TC - 1) / TC;
    n = ntr * ntc;
    @(negedge clk_i);
    base_addr_i = AW'(base); mat_rows_i = 7'(rows); mat_cols_i = 7'(cols);
    start_i = 1'b1;
    tile_ready_i = ($urandom_range(99) < 32'(ready_pct));
    @(negedge clk_i);
    start_i = 1'b0;
    c0 = cyc;
    checks++;
    if (busy_o !== 1'b1 || err_o !== 1'b0 || mem_col_o !== 7'(cols))
      begin failures++; $display("FAIL start_state: busy=%b err=%b col=%0d, expected 1 0 %0d", busy_o, err_o, mem_col_o, cols); end
    idx = 0; budget = 0;
    while (idx < n && budget < 4000) begin
      @(negedge clk_i);
      budget++;
      if (tile_valid_o) begin
        etr = idx / ntc; ec = idx % ntc;
        ea = (base + etr * TR * cols + ec * TC) % DEPTH;
        et = exp_tile(base, rows, cols, etr, ec);
        checks++;
        if (tile_row_o !== 7'(etr) || tile_col_o !== 7'(ec))
          begin failures++; $display("FAIL tile_index: got (%0d,%0d) expected (%0d,%0d)", tile_row_o, tile_col_o, etr, ec); end
        checks++;
        if (tile_last_o !== (idx == n - 1))
          begin failures++; $display("FAIL tile_last: got %b expected %b at tile %0d", tile_last_o, idx == n - 1, idx); end
        checks++;
        if (mem_addr_o !== AW'(ea))
          begin failures++; $display("FAIL tile_addr: got %0d expected %0d at (%0d,%0d)", mem_addr_o, ea, etr, ec); end
        checks++;
        if (tile_data_o !== et)
          begin failures++; $display("FAIL tile_data: got %h expected %h at (%0d,%0d)", tile_data_o, et, etr, ec); end
      end
      tile_ready_i = ($urandom_range(99) < 32'(ready_pct));
      if (tile_valid_o && tile_ready_i) idx++;
    end
    if (idx < n) begin
      failures++; $display("FAIL tile_timeout: got %0d tiles expected %0d", idx, n);
    end
    @(negedge clk_i);
    tile_ready_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || tile_valid_o !== 1'b0 || busy_o !== 1'b1)
      begin failures++; $display("FAIL done_pulse: done=%b valid=%b busy=%b, expected 1 0 1", done_o, tile_valid_o, busy_o); end
    if (chk_timing) begin
      checks++;
      if (cyc - c0 != 8)
        begin failures++; $display("FAIL start_to_last: got %0d cycles expected 8", cyc - c0); end
    end
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0)
      begin failures++; $display("FAIL after_done: done=%b busy=%b err=%b, expected 0 0 0", done_o, busy_o, err_o); end
  endtask

  // Start with dimensions the block must refuse.
  task automatic test_illegal(input int rows, input int cols);
    int dones, first, valids;
    @(negedge clk_i);
    base_addr_i = AW'(12); mat_rows_i = 7'(rows); mat_cols_i = 7'(cols);
    start_i = 1'b1; tile_ready_i = 1'b1;
    dones = 0; valids = 0; first = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o) begin dones++; if (first < 0) first = i; end
      if (tile_valid_o) valids++;
    end
    tile_ready_i = 1'b0;
    checks++;
    if (dones != 1 || first < 0 || first > 2)
      begin failures++; $display("FAIL illegal_done: got %0d pulses (first at %0d) expected 1 within 2 cycles", dones, first); end
    checks++;
    if (valids != 0)
      begin failures++; $display("FAIL illegal_valid: got %0d valid cycles expected 0", valids); end
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0)
      begin failures++; $display("FAIL illegal_err: err=%b busy=%b, expected 1 0", err_o, busy_o); end
  endtask

  task automatic test_plain();
    run_matrix(0, 8, 8, 100, 1'b1);
  endtask

  task automatic test_backpressure();
    int budget;
    bit found;
    @(negedge clk_i);
    base_addr_i = AW'(0); mat_rows_i = 7'd8; mat_cols_i = 7'd8;
    start_i = 1'b1; tile_ready_i = 1'b1;
    found = 1'b0;
    for (budget = 0; budget < 20 && !found; budget++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (tile_valid_o && tile_row_o == 7'd0 && tile_col_o == 7'd1) found = 1'b1;
    end
    tile_ready_i = 1'b0;
    checks++;
    if (!found) begin failures++; $display("FAIL bp_reach: tile (0,1) not presented, expected within 20 cycles"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (tile_valid_o !== 1'b1 || tile_row_o !== 7'd0 || tile_col_o !== 7'd1 ||
          tile_data_o !== exp_tile(0, 8, 8, 0, 1))
        begin failures++; $display("FAIL bp_hold: valid=%b tile=(%0d,%0d) data=%h, expected 1 (0,1) %h",
                                   tile_valid_o, tile_row_o, tile_col_o, tile_data_o, exp_tile(0, 8, 8, 0, 1)); end
    end
    tile_ready_i = 1'b1;
    found = 1'b0;
    for (budget = 0; budget < 4 && !found; budget++) begin
      @(negedge clk_i);
      if (tile_valid_o) found = 1'b1;
    end
    checks++;
    if (!found || tile_row_o !== 7'd1 || tile_col_o !== 7'd0 || tile_data_o !== exp_tile(0, 8, 8, 1, 0))
      begin failures++; $display("FAIL bp_next: found=%b tile=(%0d,%0d), expected (1,0)", found, tile_row_o, tile_col_o); end
    found = 1'b0;
    for (budget = 0; budget < 10 && !found; budget++) begin
      @(negedge clk_i);
      if (done_o) found = 1'b1;
    end
    tile_ready_i = 1'b0;
    checks++;
    if (!found) begin failures++; $display("FAIL bp_done: no done pulse, expected one within 10 cycles"); end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_wrap();
    run_matrix(1020, 4, 8, 100, 1'b0);
  endtask

  task automatic test_pad();
`ifdef TILE_FETCH_ZERO_PAD_EN
    run_matrix(0, 6, 6, 70, 1'b0);
    run_matrix(int'($urandom_range(DEPTH - 1)), 5, 11, 70, 1'b0);
`else
    test_illegal(6, 6);
    run_matrix(4, 4, 4, 100, 1'b0);
`endif
  endtask

  task automatic test_reset_midflight();
    int budget, dones;
    bit found;
    @(negedge clk_i);
    base_addr_i = AW'(0); mat_rows_i = 7'd8; mat_cols_i = 7'd8;
    start_i = 1'b1; tile_ready_i = 1'b1;
    found = 1'b0;
    for (budget = 0; budget < 20 && !found; budget++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (tile_valid_o && tile_row_o == 7'd1 && tile_col_o == 7'd0) found = 1'b1;
    end
    tile_ready_i = 1'b0;
    checks++;
    if (!found) begin failures++; $display("FAIL rst_reach: tile (1,0) not presented, expected within 20 cycles"); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, tile_valid_o, tile_last_o} !== 5'b0 || mem_addr_o !== '0 ||
        mem_col_o !== '0 || tile_data_o !== '0 || tile_row_o !== '0 || tile_col_o !== '0)
      begin failures++; $display("FAIL rst_async: busy=%b valid=%b addr=%0d col=%0d row=%0d, expected all 0",
                                 busy_o, tile_valid_o, mem_addr_o, mem_col_o, tile_row_o); end
    dones = 0;
    repeat (2) begin @(negedge clk_i); if (done_o) dones++; end
    rst_ni = 1'b1;
    repeat (4) begin @(negedge clk_i); if (done_o || busy_o) dones++; end
    checks++;
    if (dones != 0)
      begin failures++; $display("FAIL rst_no_done: got %0d done/busy cycles expected 0", dones); end
    run_matrix(0, 8, 8, 100, 1'b1);
  endtask

  task automatic test_random();
    int rows, cols;
    for (int i = 0; i < 6; i++) begin
`ifdef TILE_FETCH_ZERO_PAD_EN
      rows = int'($urandom_range(20, 1));
      cols = int'($urandom_range(20, 1));
`else
      rows = TR * int'($urandom_range(5, 1));
      cols = TC * int'($urandom_range(5, 1));
`endif
      run_matrix(int'($urandom_range(DEPTH - 1)), rows, cols, 60, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    test_reset();
    test_plain();
    test_backpressure();
    test_illegal(0, 8);
    run_matrix(64, 8, 4, 100, 1'b0);
    test_wrap();
    test_pad();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
